// File: rtl/move_request_ctrl.sv
// Move-request initiator: conditions buttons and gravity ticks into pending
// requests and runs a one-at-a-time checkBoard/doneLogic/finishedDrawing handshake.
module move_request_ctrl #(
  parameter int GRAVITY_TICKS = 25000000,
  parameter int CNT_W         = 25,
  parameter int TIMEOUT       = 1024
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic KeyLeft_n,
  input  logic KeyRight_n,
  input  logic KeyDown_n,
  input  logic KeyDrop_n,
  input  logic gameEnable,
  input  logic doneLogic,
  input  logic finishedDrawing,
  output logic checkBoard,
  output logic DropBlock,
  output logic LeftBlock,
  output logic RightBlock,
  output logic DownBlock,
  output logic timeoutErr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GRAVITY_TICKS - 1);
  localparam logic [TW-1:0]    T_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE,
    WAIT_DRAW
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  logic [3:0] keys_n;
  logic [3:0] fall;
  logic [3:0] set;
  logic [3:0] consume;
  logic       tick;

  // bit order {down, right, left, drop}; bit 0 is the highest priority
  assign keys_n = {KeyDown_n, KeyRight_n, KeyLeft_n, KeyDrop_n};

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q <= IDLE;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      prev_q  <= 4'hF;
      pend_q  <= 4'h0;
      cmd_q   <= 4'h0;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    sync1_d    = keys_n;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    fall       = prev_q & ~sync2_q;
    gcnt_d     = gcnt_q;
    tick       = 1'b0;
    state_d    = state_q;
    cmd_d      = cmd_q;
    tcnt_d     = tcnt_q;
    consume    = 4'h0;
    timeoutErr = 1'b0;

    if (gameEnable) begin
      if (gcnt_q == G_MAX) begin
        gcnt_d = '0;
        tick   = 1'b1;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end
    set = gameEnable ? (fall | {tick, 3'b000}) : 4'h0;

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          // isolate lowest set bit = highest priority request
          consume = pend_q & (~pend_q + 4'd1);
          cmd_d   = consume;
          tcnt_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (doneLogic) begin
          state_d = RELEASE;
        end else if (tcnt_q == T_MAX) begin
          timeoutErr = 1'b1;
          state_d    = RELEASE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RELEASE: begin
        cmd_d   = 4'h0;
        state_d = WAIT_DRAW;
      end
      WAIT_DRAW: begin
        cmd_d = 4'h0;
        if (finishedDrawing) state_d = IDLE;
      end
    endcase

    // a set landing with a consume keeps the bit
    pend_d = (pend_q & ~consume) | set;
  end

  logic cmd_vis;
  assign cmd_vis    = (state_q == HOLD) || (state_q == RELEASE);
  assign checkBoard = (state_q == HOLD);
  assign DropBlock  = cmd_vis & cmd_q[0];
  assign LeftBlock  = cmd_vis & cmd_q[1];
  assign RightBlock = cmd_vis & cmd_q[2];
  assign DownBlock  = cmd_vis & cmd_q[3];

endmodule

// File: tb/tb_move_request_ctrl.sv
// Bench for move_request_ctrl: two instances (fast and slow gravity) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_move_request_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Resetn;
  logic [3:0] keys;
  logic       gameEnable;
  logic       doneLogic;
  logic       finishedDrawing;

  logic cbA, errA, dropA, leftA, rightA, downA;
  logic cbB, errB, dropB, leftB, rightB, downB;
  logic [3:0] cmdA, cmdB;
  assign cmdA = {downA, rightA, leftA, dropA};
  assign cmdB = {downB, rightB, leftB, dropB};

  move_request_ctrl #(.GRAVITY_TICKS(8), .CNT_W(3), .TIMEOUT(16)) dut_a (
    .CLOCK_50(clk), .Resetn(Resetn),
    .KeyLeft_n(keys[1]), .KeyRight_n(keys[2]),
    .KeyDown_n(keys[3]), .KeyDrop_n(keys[0]),
    .gameEnable(gameEnable), .doneLogic(doneLogic),
    .finishedDrawing(finishedDrawing),
    .checkBoard(cbA), .DropBlock(dropA), .LeftBlock(leftA),
    .RightBlock(rightA), .DownBlock(downA), .timeoutErr(errA)
  );

  move_request_ctrl #(.GRAVITY_TICKS(4096), .CNT_W(12), .TIMEOUT(16)) dut_b (
    .CLOCK_50(clk), .Resetn(Resetn),
    .KeyLeft_n(keys[1]), .KeyRight_n(keys[2]),
    .KeyDown_n(keys[3]), .KeyDrop_n(keys[0]),
    .gameEnable(gameEnable), .doneLogic(doneLogic),
    .finishedDrawing(finishedDrawing),
    .checkBoard(cbB), .DropBlock(dropB), .LeftBlock(leftB),
    .RightBlock(rightB), .DownBlock(downB), .timeoutErr(errB)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int T = 16;
  int         gper [2] = '{8, 4096};
  logic [3:0] m_hist [2][4];
  bit   [3:0] m_pend [2];
  int         m_ph   [2];
  int         m_cmd  [2];
  int         m_hold [2];
  longint     m_en   [2];
  bit   [3:0] m_set, m_pn;
  bit         m_found;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!Resetn) begin
        for (int j = 0; j < 4; j++) m_hist[i][j] = 4'hF;
        m_pend[i] = 4'h0;
        m_ph[i]   = 0;
        m_cmd[i]  = 0;
        m_hold[i] = 0;
        m_en[i]   = 0;
      end else begin
        for (int j = 0; j < 3; j++) m_hist[i][j] = m_hist[i][j+1];
        m_hist[i][3] = keys;
        m_set = 4'h0;
        if (gameEnable) begin
          m_en[i]++;
          for (int k = 0; k < 4; k++)
            if (m_hist[i][0][k] && !m_hist[i][1][k]) m_set[k] = 1'b1;
          if (m_en[i] % gper[i] == 0) m_set[3] = 1'b1;
        end
        m_pn = m_pend[i];
        case (m_ph[i])
          0: begin
            m_found = 1'b0;
            for (int k = 0; k < 4; k++)
              if (!m_found && m_pn[k]) begin
                m_found   = 1'b1;
                m_cmd[i]  = k;
                m_pn[k]   = 1'b0;
                m_ph[i]   = 1;
                m_hold[i] = 1;
              end
          end
          1: begin
            if (doneLogic || m_hold[i] == T) m_ph[i] = 2;
            else m_hold[i]++;
          end
          2: m_ph[i] = 3;
          default: if (finishedDrawing) m_ph[i] = 0;
        endcase
        m_pend[i] = m_pn | m_set;
      end
    end
  end

  function automatic logic [5:0] m_out(input int i);
    logic [3:0] c;
    logic cb, er;
    c  = (m_ph[i] == 1 || m_ph[i] == 2) ? (4'b0001 << m_cmd[i]) : 4'h0;
    cb = (m_ph[i] == 1);
    er = (m_ph[i] == 1) && !doneLogic && (m_hold[i] == T);
    return {cb, er, c};
  endfunction

  // ---------------- per-cycle compare + issue log ----------------
  bit chk_en = 1'b0;
  logic cbB_prev = 1'b0;
  logic [3:0] issued [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmpA", {cbA, errA, cmdA}, m_out(0));
      chk("cmpB", {cbB, errB, cmdB}, m_out(1));
      if (cbB && !cbB_prev) issued.push_back(cmdB);
    end
    cbB_prev = cbB;
  end

  // ---------------- logic-FSM / draw-engine responder ----------------
  bit resp_en = 1'b0;
  bit sel     = 1'b0;
  bit man_fin = 1'b0;
  int hc = 0;
  int fc = 0;

  always @(posedge clk) begin
    #1;
    if (!resp_en) begin
      hc = 0;
      fc = 0;
      doneLogic       = 1'b0;
      finishedDrawing = man_fin;
    end else begin
      finishedDrawing = 1'b0;
      if (sel ? cbB : cbA) begin
        hc++;
        doneLogic = (hc >= 3);
      end else begin
        if (hc > 0) fc = 3;
        hc = 0;
        doneLogic = 1'b0;
        if (fc > 0) begin
          fc--;
          finishedDrawing = (fc == 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Resetn     = 1'b0;
    keys       = 4'hF;
    gameEnable = 1'b0;
    tick();
  endtask

  task automatic wait_cbB(input int lim);
    int n = 0;
    while (!cbB && n < lim) begin
      tick();
      n++;
    end
    chk("wait_cbB", {31'd0, cbB}, 32'd1);
  endtask

  initial begin
    Resetn          = 1'b0;
    keys            = 4'hF;
    gameEnable      = 1'b0;
    doneLogic       = 1'b0;
    finishedDrawing = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    #1;
    chk("rst_A", {cbA, errA, cmdA}, 0);
    chk("rst_B", {cbB, errB, cmdB}, 0);

    // gravity on instance A
    resp_en = 1'b1; sel = 1'b0; gameEnable = 1'b1; Resetn = 1'b1;
    repeat (8) tick();
    #1 chk("grav_c8", {31'd0, cbA}, 0);
    tick();
    #1 chk("grav_c9", {cbA, cmdA}, 5'b1_1000);
    repeat (7) tick();
    #1 chk("grav_c16", {31'd0, cbA}, 0);
    tick();
    #1 chk("grav_c17", {cbA, cmdA}, 5'b1_1000);
    repeat (30) tick();

    // left press latency and single request while held
    do_reset();
    sel = 1'b1; gameEnable = 1'b1; Resetn = 1'b1; keys[1] = 1'b0;
    issued.delete();
    repeat (3) tick();
    #1 chk("lat_c3", {31'd0, cbB}, 0);
    tick();
    #1 chk("lat_c4", {cbB, cmdB}, 5'b1_0010);
    repeat (3) tick();
    #1 chk("rel_c7", {cbB, cmdB}, 5'b0_0010);
    tick();
    #1 chk("wd_c8", {cbB, cmdB}, 5'b0_0000);
    repeat (92) tick();
    keys = 4'hF;
    repeat (10) tick();
    chk("held_once", issued.size(), 1);

    // drop + left + down pending together
    do_reset();
    Resetn = 1'b1; gameEnable = 1'b1; keys = 4'b0100;
    issued.delete();
    repeat (5) tick();
    keys = 4'hF;
    repeat (60) tick();
    chk("prio_n", issued.size(), 3);
    chk("prio_0", issued.size() > 0 ? issued[0] : 4'h0, 4'b0001);
    chk("prio_1", issued.size() > 1 ? issued[1] : 4'h0, 4'b0010);
    chk("prio_2", issued.size() > 2 ? issued[2] : 4'h0, 4'b1000);

    // left pressed during hold of a down request
    do_reset();
    Resetn = 1'b1; gameEnable = 1'b1; keys[3] = 1'b0;
    issued.delete();
    wait_cbB(20);
    keys[1] = 1'b0;
    repeat (100) tick();
    keys = 4'hF;
    repeat (20) tick();
    chk("mid_n", issued.size(), 2);
    chk("mid_0", issued.size() > 0 ? issued[0] : 4'h0, 4'b1000);
    chk("mid_1", issued.size() > 1 ? issued[1] : 4'h0, 4'b0010);

    // timeout: doneLogic never returned
    do_reset();
    resp_en = 1'b0;
    Resetn = 1'b1; gameEnable = 1'b1; keys[0] = 1'b0;
    repeat (18) tick();
    #1 chk("to_c18", {cbB, errB}, 2'b10);
    tick();
    #1 chk("to_c19", {cbB, errB, cmdB}, 6'b11_0001);
    tick();
    #1 chk("to_rel", {cbB, errB, cmdB}, 6'b00_0001);
    tick();
    #1 chk("to_wait", {cbB, errB, cmdB}, 6'b00_0000);
    keys = 4'hF; man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    repeat (10) tick();

    // reset in the middle of HOLD, stale press discarded
    do_reset();
    Resetn = 1'b1; gameEnable = 1'b1; keys[1] = 1'b0;
    repeat (4) tick();
    #1 chk("rh_hold", {31'd0, cbB}, 1);
    keys = 4'b1011;
    tick();
    keys = 4'hF; Resetn = 1'b0;
    tick();
    #1 chk("rh_reset", {cbB, errB, cmdB}, 0);
    Resetn = 1'b1;
    issued.delete();
    repeat (30) tick();
    chk("rh_stale", issued.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_request_ctrl.md
Name: move_request_ctrl

Overview:
- Initiator side of the move handshake into the game-logic FSM.
- Synchronises and edge-detects the four player buttons and generates the gravity tick. It latches these as pending move requests.
- Issues one move at a time: a one-hot DropBlock/LeftBlock/RightBlock/DownBlock command plus checkBoard, held until the logic FSM returns doneLogic. It then waits for finishedDrawing before issuing the next move.

Parameters:
- GRAVITY_TICKS, 25000000, CLOCK_50 cycles between automatic down requests (0.5 s).
- CNT_W, 25, width of the gravity counter; must satisfy 2^CNT_W >= GRAVITY_TICKS.
- TIMEOUT, 1024, maximum cycles checkBoard is held without doneLogic before forced release.

Ports:
- CLOCK_50  in  1  system clock.
- Resetn  in  1  synchronous, active-low reset.
- KeyLeft_n, KeyRight_n, KeyDown_n, KeyDrop_n  in  1 each  raw active-low buttons, asynchronous to CLOCK_50.
- gameEnable  in  1  when 0: gravity counter frozen and no new requests latched.
- doneLogic  in  1  from logic FSM; high while it sits in its completion state.
- finishedDrawing  in  1  from the draw engine; pulse or level meaning the frame is redrawn.
- checkBoard  out  1  move request valid.
- DropBlock, LeftBlock, RightBlock, DownBlock  out  1 each  one-hot move command.
- timeoutErr  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (Resetn=0 at a clock edge), applies in any state including mid-handshake:
  - state=IDLE; all outputs 0.
  - Pending bits 0; gravity counter 0; timeout counter 0; synchroniser and edge flops set to 1 (released).
- Input conditioning:
  - Each key passes a 2-flop synchroniser, then a falling-edge detect.
  - A press sets pending[key] one cycle later, only if gameEnable=1.
  - Holding a key produces exactly one request.
- Gravity:
  - While gameEnable=1 the counter increments every cycle.
  - At GRAVITY_TICKS-1 it wraps to 0 and sets pendDown.
  - The counter keeps running during a handshake.
- Pending rules:
  - Setting a bit that is already set has no effect; requests do not queue deeper than 1 per direction.
  - If a set and a consume of the same bit happen in the same cycle, set wins and the bit stays 1.
- States:
  - IDLE: if any pending bit is set, choose by priority Drop > Left > Right > Down, load the one-hot command register, clear that pending bit, and go to HOLD next cycle. Otherwise stay in IDLE.
  - HOLD: checkBoard=1; command held stable. On doneLogic=1 go to RELEASE. If the timeout counter reaches TIMEOUT-1, pulse timeoutErr and go to RELEASE. The timeout counter resets on HOLD entry.
  - RELEASE: checkBoard=0; command still held for this one cycle, because the logic FSM samples the command on its exit from the completion state. Always go to WAIT_DRAW.
  - WAIT_DRAW: checkBoard=0; command=0. On finishedDrawing=1 go to IDLE.
- Latency:
  - Key edge to checkBoard=1 takes 4 cycles (2 sync, 1 edge/pending, 1 IDLE→HOLD), provided the block is in IDLE.
- Invariants:
  - At most one command bit is high at any time.
  - The command never changes while checkBoard=1.
  - checkBoard is never high outside HOLD.
- finishedDrawing arriving while in IDLE or HOLD is ignored.
- gameEnable dropping mid-handshake does not abort the handshake. Requests already pending stay pending and issue normally once in IDLE.

Test Plan:
- GRAVITY_TICKS=8, no keys, doneLogic returned 3 cycles after checkBoard, finishedDrawing 2 cycles later -> DownBlock+checkBoard first rises at cycle 9 after reset release; repeats every 8 cycles; one-hot holds.
- KeyLeft_n low at cycle 0 while IDLE -> checkBoard=1 and LeftBlock=1 at cycle 4; after doneLogic, RELEASE shows checkBoard=0 with LeftBlock=1 for exactly 1 cycle, then 0.
- Drop, Left and Down pending simultaneously -> issued in order Drop, Left, Down across three handshakes, each gated by finishedDrawing.
- Left pressed during HOLD of a Down request -> Down completes unchanged; Left issues after finishedDrawing; key held 100 cycles -> only 1 Left request.
- TIMEOUT=16, doneLogic never asserted -> checkBoard held 16 cycles, then timeoutErr pulses for 1 cycle; FSM proceeds to RELEASE, then WAIT_DRAW.
- Resetn=0 during HOLD -> next cycle checkBoard=0, commands 0, pending cleared; a stale key press made before reset produces no request.
